mem_access_arbiter: RTL and testbench

Sequences every access to the 512-byte RAM (MOV/MOC handshake) and shares it between two requesters: the instruction-fetch port (if_*) and the load/store data port (dm_*).
- Drives RAM address, write data, MOV, MemRead and MemWrite.
- Waits for MOC, with a timeout.
- Returns read data and a done pulse to the winning requester.
- Sits between the control unit/datapath and ram512x8, replacing the MAR/MDR/MOV sequencing spread across the control states.

---
 rtl/mem_arb_pkg.sv | 39 +++
 rtl/mem_arb_priority.sv | 45 ++++
 rtl/mem_access_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the RAM access arbiter: FSM states, error codes,
// requester identifiers and the address legality check applied at grant time.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } err_code_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

    localparam int MEM_BYTES      = 512;
    localparam int WORD_BYTES     = 4;
    localparam int LAST_WORD_ADDR = MEM_BYTES - WORD_BYTES;

    // Misalignment takes precedence, so 0x1FD..0x1FF report misaligned.
    function automatic err_code_e check_addr(input logic [31:0] addr);
        err_code_e code;
        if (addr[1:0] != 2'b00) begin
            code = ERR_MISALIGN;
        end else if (addr > 32'(LAST_WORD_ADDR)) begin
            code = ERR_RANGE;
        end else begin
            code = ERR_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/mem_arb_priority.sv
// Winner selection between fetch and data requesters, with a starvation
// counter that forces a fetch grant after STARVE_LIMIT data grants.
module mem_arb_priority
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic if_req,
    input  logic dm_req,
    input  logic grant_en,
    output logic win_valid,
    output logic win_id
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             fetch_forced;

    always_comb begin
        fetch_forced = if_req && (starve_q == CNT_W'(STARVE_LIMIT));
        win_valid    = if_req || dm_req;
        win_id       = (dm_req && !fetch_forced) ? REQ_DM : REQ_IF;
        starve_d     = starve_q;
        // Only data grants made while a fetch waits count toward starvation.
        if (grant_en && win_valid) begin
            if (win_id == REQ_IF) begin
                starve_d = '0;
            end else if (if_req) begin
                starve_d = starve_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Sequences MOV/MOC handshakes to the 512-byte RAM and shares it between the
// instruction-fetch and load/store ports; all outputs are registered.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = 15,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mov,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              moc,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    err_code_e         err_code_q, err_code_d, addr_chk;
    logic              id_q, id_d, we_q, we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, sel_addr;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, sel_wdata;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic              mov_q, mov_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic              if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
    logic              if_done_q, if_done_d, dm_done_q, dm_done_d, err_q, err_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              grant_en, win_valid, win_id, sel_we;

    assign grant_en = (state_q == IDLE);

    mem_arb_priority #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_priority (
        .clock    (clock),
        .reset    (reset),
        .if_req   (if_req),
        .dm_req   (dm_req),
        .grant_en (grant_en),
        .win_valid(win_valid),
        .win_id   (win_id)
    );

    always_comb begin
        // NOTE: every _d takes its hold value (or pulse default) first, so no path infers a latch.
        state_d     = state_q;
        id_d        = id_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mov_d       = mov_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        err_code_d  = err_code_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        tcnt_d      = tcnt_q;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        err_d       = 1'b0;

        sel_addr  = (win_id == REQ_DM) ? dm_addr : if_addr;
        sel_we    = (win_id == REQ_DM) && dm_we;
        sel_wdata = (win_id == REQ_DM) ? dm_wdata : '0;
        addr_chk  = check_addr(32'(sel_addr));

        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    id_d        = win_id;
                    we_d        = sel_we;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    err_code_d  = addr_chk;
                    if_gnt_d    = (win_id == REQ_IF);
                    dm_gnt_d    = (win_id == REQ_DM);
                    // Illegal addresses never touch the RAM.
                    if (addr_chk != ERR_NONE) begin
                        mem_read_d  = 1'b0;
                        mem_write_d = 1'b0;
                        state_d     = RESP;
                    end else begin
                        mem_read_d  = ~sel_we;
                        mem_write_d = sel_we;
                        state_d     = SETUP;
                    end
                end
            end
            SETUP: begin
                mov_d   = 1'b1;
                tcnt_d  = '0;
                state_d = STROBE;
            end
            STROBE: begin
                if (moc) begin
                    if (!we_q && id_q == REQ_IF) if_rdata_d = mem_rdata;
                    if (!we_q && id_q == REQ_DM) dm_rdata_d = mem_rdata;
                    mov_d       = 1'b0;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = RESP;
                end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
                    mov_d       = 1'b0;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = RESP;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            RESP: begin
                if_done_d = (id_q == REQ_IF);
                dm_done_d = (id_q == REQ_DM);
                err_d     = (err_code_q != ERR_NONE);
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            id_q        <= REQ_IF;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mov_q       <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            tcnt_q      <= '0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q     <= state_d;
            id_q        <= id_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mov_q       <= mov_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            err_code_q  <= err_code_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            tcnt_q      <= tcnt_d;
            if_gnt_q    <= if_gnt_d;
            dm_gnt_q    <= dm_gnt_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            err_q       <= err_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign dm_gnt    = dm_gnt_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mov       = mov_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed vector table, arbitration
// and reset sequences, and random accesses scored against a transaction-level model.
module tb_mem_access_arbiter;

    localparam int TIMEOUT = 15;
    localparam int STARVE  = 3;

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        int          delay;     // STROBE cycle on which moc rises; 0 = never
        int          exp_lat;   // cycles from gnt pulse to done pulse
        int          exp_mov;   // cycles mov is high
        bit          exp_err;
        logic [1:0]  exp_code;
        logic [31:0] exp_rd;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req, if_gnt, if_done;
    logic [8:0]  if_addr;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_done;
    logic [8:0]  dm_addr;
    logic [31:0] dm_wdata, dm_rdata;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mov, mem_read, mem_write, moc, err;
    logic [1:0]  err_code;

    logic        w_if_req, w_if_gnt, w_if_done, w_dm_req, w_dm_we, w_dm_gnt, w_dm_done;
    logic [9:0]  w_if_addr, w_dm_addr, w_mem_addr;
    logic [31:0] w_if_rdata, w_dm_wdata, w_dm_rdata, w_mem_wdata, w_mem_rdata;
    logic        w_mov, w_mem_read, w_mem_write, w_moc, w_err;
    logic [1:0]  w_err_code;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] ram     [128];
    logic [31:0] exp_mem [128];
    logic [31:0] exp_if, exp_dm;
    int          moc_delay = 0;
    int          mov_cnt   = 0;
    bit          gnt_log[$];
    vec_t        vecs[7];

    always #5 clock = ~clock;

    mem_access_arbiter #(
        .ADDR_W(9), .DATA_W(32), .TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE)
    ) u_dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mov(mov), .mem_read(mem_read),
        .mem_write(mem_write), .moc(moc), .mem_rdata(mem_rdata), .err(err), .err_code(err_code)
    );

    mem_access_arbiter #(
        .ADDR_W(10), .DATA_W(32), .TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE)
    ) u_dut10 (
        .clock(clock), .reset(reset),
        .if_req(w_if_req), .if_addr(w_if_addr), .if_gnt(w_if_gnt), .if_done(w_if_done), .if_rdata(w_if_rdata),
        .dm_req(w_dm_req), .dm_we(w_dm_we), .dm_addr(w_dm_addr), .dm_wdata(w_dm_wdata),
        .dm_gnt(w_dm_gnt), .dm_done(w_dm_done), .dm_rdata(w_dm_rdata),
        .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mov(w_mov), .mem_read(w_mem_read),
        .mem_write(w_mem_write), .moc(w_moc), .mem_rdata(w_mem_rdata), .err(w_err), .err_code(w_err_code)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock; sample just after the edge, then let the RAM responder react.
    task automatic step();
        @(posedge clock);
        #1;
        if (if_gnt) gnt_log.push_back(1'b0);
        if (dm_gnt) gnt_log.push_back(1'b1);
        if (mov) begin
            mov_cnt++;
            if (moc_delay > 0 && mov_cnt >= moc_delay) begin
                moc       = 1'b1;
                mem_rdata = ram[mem_addr[8:2]];
                if (mem_write) ram[mem_addr[8:2]] = mem_wdata;
            end else begin
                moc = 1'b0;
            end
        end else begin
            mov_cnt = 0;
            moc     = 1'b0;
        end
    endtask

    // Transaction-level expectation: outcome follows from address legality and moc timing alone.
    function automatic void model(inout vec_t v);
        int word;
        word = int'(v.addr) / 4;
        if (v.addr % 4 != 0)          v.exp_code = 2'b01;
        else if (int'(v.addr) > 508)  v.exp_code = 2'b10;
        else if (v.delay == 0)        v.exp_code = 2'b11;
        else                          v.exp_code = 2'b00;
        v.exp_err = (v.exp_code != 2'b00);
        if (v.exp_code == 2'b01 || v.exp_code == 2'b10) v.exp_mov = 0;
        else if (v.exp_code == 2'b11)                   v.exp_mov = TIMEOUT;
        else                                            v.exp_mov = v.delay;
        v.exp_lat = (v.exp_mov == 0) ? 1 : v.exp_mov + 2;
        if (v.exp_code == 2'b00) begin
            if (v.we)         exp_mem[word] = v.wdata;
            else if (v.is_dm) exp_dm = exp_mem[word];
            else              exp_if = exp_mem[word];
        end
        v.exp_rd = v.is_dm ? exp_dm : exp_if;
    endfunction

    task automatic apply(input string tag, input vec_t v);
        int          lat, mov_hi, gnt_cyc;
        bit          gnt_seen, ctrl_ok, err_o;
        logic [1:0]  code_o;
        logic [31:0] rd_o;
        lat = -1; mov_hi = 0; gnt_cyc = 0; gnt_seen = 0; ctrl_ok = 1; err_o = 0;
        code_o = 2'bxx; rd_o = 'x;
        moc_delay = v.delay;
        if (v.is_dm) begin
            dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        for (int c = 0; c < 60; c++) begin
            step();
            if (!gnt_seen && (v.is_dm ? dm_gnt : if_gnt)) begin
                gnt_seen = 1; gnt_cyc = c;
            end
            if (mov) begin
                mov_hi++;
                if (mem_read !== !v.we || mem_write !== v.we || mem_addr !== v.addr ||
                    (v.we && mem_wdata !== v.wdata)) ctrl_ok = 0;
            end
            if (v.is_dm ? dm_done : if_done) begin
                lat    = gnt_seen ? c - gnt_cyc : -2;
                err_o  = err;
                code_o = err_code;
                rd_o   = v.is_dm ? dm_rdata : if_rdata;
                break;
            end
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        step();
        check({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
        check({tag, "_mov_cycles"}, 64'(mov_hi), 64'(v.exp_mov));
        check({tag, "_err"}, 64'(err_o), 64'(v.exp_err));
        check({tag, "_err_code"}, 64'(code_o), 64'(v.exp_code));
        check({tag, "_rdata"}, 64'(rd_o), 64'(v.exp_rd));
        check({tag, "_bus_ctrl"}, 64'(ctrl_ok), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   cnt, dones, fnd;
        bit   exp_id, w_mov_seen, w_err_o;
        logic [1:0] w_code_o;

        reset = 1'b0; moc = 1'b0; mem_rdata = '0;
        if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        w_if_req = 1'b0; w_if_addr = '0; w_dm_req = 1'b0; w_dm_we = 1'b0; w_dm_addr = '0;
        w_dm_wdata = '0; w_moc = 1'b0; w_mem_rdata = '0;
        for (int i = 0; i < 128; i++) begin
            ram[i] = $urandom; exp_mem[i] = ram[i];
        end
        ram[4]   = 32'h2401002C; exp_mem[4]   = 32'h2401002C;
        ram[127] = 32'h12345678; exp_mem[127] = 32'h12345678;
        exp_if = '0; exp_dm = '0;

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check("reset_ctrl", 64'({mov, mem_read, mem_write, if_gnt, dm_gnt, if_done, dm_done, err, err_code}), 64'(0));
        check("reset_if_rdata", 64'(if_rdata), 64'(0));
        check("reset_dm_rdata", 64'(dm_rdata), 64'(0));
        check("reset_mem_addr", 64'(mem_addr), 64'(0));
        check("reset_mem_wdata", 64'(mem_wdata), 64'(0));
        reset = 1'b1;
        step();

        // Directed vectors: fetch, store, alignment/range boundaries, timeout, recovery.
        vecs[0] = '{1'b0, 1'b0, 9'h010, 32'h0,        2, 4,  2,  1'b0, 2'b00, 32'h2401002C};
        vecs[1] = '{1'b1, 1'b1, 9'h020, 32'hDEADBEEF, 1, 3,  1,  1'b0, 2'b00, 32'h00000000};
        vecs[2] = '{1'b1, 1'b0, 9'h011, 32'h0,        1, 1,  0,  1'b1, 2'b01, 32'h00000000};
        vecs[3] = '{1'b1, 1'b0, 9'h1FC, 32'h0,        1, 3,  1,  1'b0, 2'b00, 32'h12345678};
        vecs[4] = '{1'b1, 1'b0, 9'h1FD, 32'h0,        1, 1,  0,  1'b1, 2'b01, 32'h12345678};
        vecs[5] = '{1'b0, 1'b0, 9'h040, 32'h0,        0, 17, 15, 1'b1, 2'b11, 32'h2401002C};
        vecs[6] = '{1'b0, 1'b0, 9'h020, 32'h0,        1, 3,  1,  1'b0, 2'b00, 32'hDEADBEEF};
        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            model(v);  // keep the model's memory/rdata shadow in step
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Contention: both ports held; data wins until STARVE grants, then fetch.
        moc_delay = 1;
        gnt_log.delete();
        dm_we = 1'b0; dm_addr = 9'h100; if_addr = 9'h104;
        if_req = 1'b1; dm_req = 1'b1;
        for (int c = 0; c < 200 && gnt_log.size() < 8; c++) step();
        if_req = 1'b0; dm_req = 1'b0;
        repeat (6) step();
        check("contend_grant_count", 64'(gnt_log.size()), 64'(8));
        cnt = 0;
        for (int i = 0; i < 8 && i < gnt_log.size(); i++) begin
            if (cnt == STARVE) begin exp_id = 1'b0; cnt = 0; end
            else begin exp_id = 1'b1; cnt++; end
            check($sformatf("contend_grant%0d", i), 64'(gnt_log[i]), 64'(exp_id));
        end
        exp_dm = exp_mem[9'h100 / 4];
        exp_if = exp_mem[9'h104 / 4];

        // Random single-requester traffic against the model.
        for (int i = 0; i < 40; i++) begin
            v.is_dm = 1'($urandom_range(0, 1));
            v.we    = v.is_dm ? 1'($urandom_range(0, 1)) : 1'b0;
            if ($urandom_range(0, 9) == 0) v.addr = {7'($urandom_range(0, 127)), 2'($urandom_range(1, 3))};
            else                           v.addr = {7'($urandom_range(0, 127)), 2'b00};
            v.wdata = $urandom;
            v.delay = $urandom_range(0, 4);
            model(v);
            apply($sformatf("rnd%0d", i), v);
        end

        // Reset in the middle of STROBE.
        moc_delay = 0;
        if_addr = 9'h030; if_req = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (mov) break;
        end
        check("midrst_mov_before", 64'(mov), 64'(1));
        step(); step();
        #1 reset = 1'b0;
        #1;
        check("midrst_mov_async", 64'(mov), 64'(0));
        check("midrst_ctrl_async", 64'({mem_read, mem_write, if_gnt, if_done, err, err_code}), 64'(0));
        check("midrst_if_rdata", 64'(if_rdata), 64'(0));
        if_req = 1'b0;
        dones = 0;
        repeat (3) begin
            step();
            if (if_done || dm_done) dones++;
        end
        reset = 1'b1;
        check("midrst_no_done", 64'(dones), 64'(0));
        exp_if = '0; exp_dm = '0;
        v = '{1'b0, 1'b0, 9'h010, 32'h0, 1, 0, 0, 1'b0, 2'b00, 32'h0};
        model(v);
        apply("post_reset_fetch", v);

        // Out-of-range code, only reachable with a 10-bit address.
        w_dm_addr = 10'h200; w_dm_we = 1'b0; w_dm_req = 1'b1;
        fnd = 0; w_mov_seen = 0; w_err_o = 0; w_code_o = 2'bxx;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            #1;
            if (w_mov) w_mov_seen = 1;
            if (w_dm_done) begin
                fnd = 1; w_err_o = w_err; w_code_o = w_err_code;
                break;
            end
        end
        w_dm_req = 1'b0;
        check("range_done", 64'(fnd), 64'(1));
        check("range_err", 64'(w_err_o), 64'(1));
        check("range_err_code", 64'(w_code_o), 64'(2'b10));
        check("range_no_mov", 64'(w_mov_seen), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
